// File: rtl/ad9226_capture.sv
// AD9226 capture: divided conversion clock, pipeline flush, block averaging
// and a single-entry output register with a sticky overrun flag.
module ad9226_capture #(
  parameter int ADC_MSB     = 11,
  parameter int CLK_DIV     = 4,
  parameter int BIT_REVERSE = 0,
  parameter int DECIM_LOG2  = 2
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic [ADC_MSB:0]          ADC_DATA,
  output logic                      ADC_CLK,
  output logic signed [ADC_MSB:0]   SAMPLE,
  output logic                      SAMPLE_VALID,
  input  logic                      SAMPLE_READY,
  output logic                      OVERRUN,
  input  logic                      CLEAR_OVERRUN
);

  localparam int DW      = $clog2(CLK_DIV);
  localparam int AW      = ADC_MSB + 1 + DECIM_LOG2;
  localparam int GW      = DECIM_LOG2 + 1;
  localparam int DISCARD = 8;

  logic [DW-1:0]            div_cnt;
  logic [3:0]               disc_cnt;
  logic [GW-1:0]            grp_cnt;
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     acc_sum;
  logic [ADC_MSB:0]         data_map;
  logic [ADC_MSB:0]         cap_data;
  logic                     cap_vld;
  logic signed [ADC_MSB:0]  cap_signed;
  logic signed [ADC_MSB:0]  result;
  logic                     strobe;
  logic                     grp_last;
  logic                     res_vld;

  always_comb begin
    data_map = '0;
    for (int i = 0; i <= ADC_MSB; i++) begin
      data_map[i] = (BIT_REVERSE != 0) ? ADC_DATA[ADC_MSB-i] : ADC_DATA[i];
    end
  end

  assign strobe     = ENABLE && (div_cnt == DW'(CLK_DIV - 1));
  // Straight binary to two's complement is just an MSB flip.
  assign cap_signed = {~cap_data[ADC_MSB], cap_data[ADC_MSB-1:0]};
  assign acc_sum    = acc + AW'(cap_signed);
  assign grp_last   = (grp_cnt == GW'((1 << DECIM_LOG2) - 1));
  assign res_vld    = ENABLE && cap_vld && grp_last;
  // Taking the upper bits of the sum is the floor arithmetic shift.
  assign result     = acc_sum[ADC_MSB+DECIM_LOG2:DECIM_LOG2];

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      div_cnt  <= '0;
      ADC_CLK  <= 1'b0;
      disc_cnt <= '0;
      cap_vld  <= 1'b0;
      cap_data <= '0;
      acc      <= '0;
      grp_cnt  <= '0;
    end else if (!ENABLE) begin
      div_cnt  <= '0;
      ADC_CLK  <= 1'b0;
      disc_cnt <= '0;
      cap_vld  <= 1'b0;
      acc      <= '0;
      grp_cnt  <= '0;
    end else begin
      div_cnt <= strobe ? '0 : div_cnt + 1'b1;
      ADC_CLK <= (div_cnt < DW'(CLK_DIV / 2));
      cap_vld <= strobe && (disc_cnt == 4'(DISCARD));
      if (strobe) begin
        cap_data <= data_map;
        if (disc_cnt != 4'(DISCARD)) disc_cnt <= disc_cnt + 1'b1;
      end
      if (cap_vld) begin
        if (grp_last) begin
          acc     <= '0;
          grp_cnt <= '0;
        end else begin
          acc     <= acc_sum;
          grp_cnt <= grp_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      SAMPLE       <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      if (res_vld && (!SAMPLE_VALID || SAMPLE_READY)) begin
        SAMPLE       <= result;
        SAMPLE_VALID <= 1'b1;
      end else if (SAMPLE_READY) begin
        SAMPLE_VALID <= 1'b0;
      end
      // A fresh drop wins over a clear request on the same edge.
      if (res_vld && SAMPLE_VALID && !SAMPLE_READY) OVERRUN <= 1'b1;
      else if (CLEAR_OVERRUN)                       OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad9226_capture.sv
// Bench for ad9226_capture: per-ADC_CLK-period sample model feeding a result
// queue that a separate monitor drains whenever the DUT loads SAMPLE.
module tb_ad9226_capture;

  localparam int GROUP = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET = 1'b1;
  logic ENABLE = 1'b0;
  logic SAMPLE_READY = 1'b1;
  logic CLEAR_OVERRUN = 1'b0;
  logic [11:0] ADC_DATA = 12'h000;
  logic ADC_CLK, SAMPLE_VALID, OVERRUN;
  logic signed [11:0] SAMPLE;
  logic rev_clk, rev_valid, rev_ovr;
  logic signed [11:0] rev_sample;

  ad9226_capture dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .ENABLE(ENABLE), .ADC_DATA(ADC_DATA),
    .ADC_CLK(ADC_CLK), .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY), .OVERRUN(OVERRUN), .CLEAR_OVERRUN(CLEAR_OVERRUN)
  );

  ad9226_capture #(.BIT_REVERSE(1)) dut_rev (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .ENABLE(ENABLE), .ADC_DATA(ADC_DATA),
    .ADC_CLK(rev_clk), .SAMPLE(rev_sample), .SAMPLE_VALID(rev_valid),
    .SAMPLE_READY(SAMPLE_READY), .OVERRUN(rev_ovr), .CLEAR_OVERRUN(CLEAR_OVERRUN)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;
  int q[$];
  int pat[$];
  int rises = 0;
  int acc = 0;
  int grp = 0;
  int const_val = 'hFFF;
  bit rand_data = 0;
  bit rand_ready = 0;
  bit just_pushed = 0;
  bit clk_prev = 0;
  int const_list[4] = '{'hFFF, 'h000, 'h800, 'h001};
  bit mon_pv = 0;
  bit mon_pr = 0;
  logic signed [11:0] mon_ps = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int conv(input int v);
    return v - 2048;
  endfunction

  function automatic int rev12(input int v);
    int r = 0;
    for (int i = 0; i < 12; i++) if (v[i]) r |= (1 << (11 - i));
    return r;
  endfunction

  function automatic int floor_div(input int s, input int d);
    int r = s / d;
    if ((s % d) != 0 && s < 0) r--;
    return r;
  endfunction

  // One ADC_CLK rising edge = one conversion; the first 8 after enable are flushed.
  task automatic on_rise();
    int v;
    if (pat.size() > 0) v = pat.pop_front();
    else if (rand_data) v = int'($urandom_range(4095));
    else v = const_val;
    ADC_DATA = 12'(v);
    rises++;
    if (rises > 8) begin
      acc += conv(v);
      grp++;
      if (grp == GROUP) begin
        q.push_back(floor_div(acc, GROUP));
        acc = 0;
        grp = 0;
        just_pushed = 1;
      end
    end
  endtask

  task automatic model_clear();
    rises = 0;
    acc = 0;
    grp = 0;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    just_pushed = 0;
    if (ADC_CLK && !clk_prev) on_rise();
    clk_prev = ADC_CLK;
    if (rand_ready) SAMPLE_READY = ($urandom_range(3) != 0);
  endtask

  task automatic set_en(input bit b);
    ENABLE = b;
    if (!b) model_clear();
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!SAMPLE_VALID && n < lim) begin
      step();
      n++;
    end
  endtask

  task automatic align();
    int k = 0;
    do begin
      step();
      k++;
    end while (!just_pushed && k < 200);
    if (!just_pushed) chk("align_timeout", 0, 1);
  endtask

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (SAMPLE_VALID && (!mon_pv || mon_pr)) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample: got %0d expected no load", SAMPLE);
        end else begin
          chk("sample", int'(SAMPLE), q.pop_front());
        end
      end else if (SAMPLE_VALID && mon_pv && !mon_pr) begin
        chk("sample_hold", int'(SAMPLE), int'(mon_ps));
      end
      mon_pv = SAMPLE_VALID;
      mon_pr = SAMPLE_READY;
      mon_ps = SAMPLE;
    end
  end

  initial begin
    int n;
    int r0;
    int k;

    repeat (3) step();
    chk("rst_adc_clk", ADC_CLK, 0);
    chk("rst_sample", int'(SAMPLE), 0);
    chk("rst_valid", SAMPLE_VALID, 0);
    chk("rst_overrun", OVERRUN, 0);

    // Start: constant full-scale, check clock pattern and first-output latency.
    const_val = 'hFFF;
    RESET = 0;
    set_en(1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("adc_clk_pattern", {ADC_CLK, rev_clk}, ((i - 1) % 4 < 2) ? 3 : 0);
    end
    wait_valid(100, n);
    chk("first_latency", n + 8, 49);

    foreach (const_list[i]) begin
      const_val = const_list[i];
      repeat (128) step();
      chk("rev_sample", int'(rev_sample), conv(rev12(const_list[i])));
    end

    align();
    pat.push_back('h900); pat.push_back('h900); pat.push_back('h700); pat.push_back('h700);
    pat.push_back('h801); pat.push_back('h801); pat.push_back('h801); pat.push_back('h802);
    const_val = 'h800;
    repeat (48) step();

    rand_data = 1;
    rand_ready = 1;
    repeat (640) step();
    chk("no_overrun_random", OVERRUN, 0);
    rand_data = 0;
    rand_ready = 0;
    SAMPLE_READY = 1;
    const_val = 'h800;

    // Overrun: hold ready low across two groups.
    align();
    repeat (4) pat.push_back('hA00);
    repeat (4) pat.push_back('hC00);
    repeat (5) step();
    SAMPLE_READY = 0;
    repeat (40) step();
    chk("ovr_sample", int'(SAMPLE), 512);
    chk("ovr_valid", SAMPLE_VALID, 1);
    chk("ovr_flag", OVERRUN, 1);
    chk("ovr_flag_rev", rev_ovr, 1);
    set_en(0);
    repeat (2) step();
    chk("disable_keeps_valid", SAMPLE_VALID, 1);
    chk("disable_keeps_sample", int'(SAMPLE), 512);
    q.delete();
    SAMPLE_READY = 1;
    CLEAR_OVERRUN = 1;
    step();
    CLEAR_OVERRUN = 0;
    chk("ovr_clear_valid", SAMPLE_VALID, 0);
    chk("ovr_clear_flag", OVERRUN, 0);

    // Enable drop mid-group: partial data must not contribute.
    const_val = 'h800;
    set_en(1);
    wait_valid(100, n);
    chk("enable_latency", n, 49);
    align();
    r0 = rises;
    pat.push_back('hFFF); pat.push_back('hFFF);
    k = 0;
    while (rises < r0 + 2 && k < 20) begin
      step();
      k++;
    end
    repeat (3) step();
    set_en(0);
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("adc_clk_off", ADC_CLK, 0);
    end
    set_en(1);
    wait_valid(100, n);
    chk("reenable_latency", n, 49);

    // Reset with a pending sample and overrun set.
    const_val = 'h900;
    SAMPLE_READY = 0;
    k = 0;
    while (!OVERRUN && k < 200) begin
      step();
      k++;
    end
    chk("pre_rst_overrun", OVERRUN, 1);
    chk("pre_rst_valid", SAMPLE_VALID, 1);
    RESET = 1;
    step();
    chk("rst_pulse_valid", SAMPLE_VALID, 0);
    chk("rst_pulse_overrun", OVERRUN, 0);
    chk("rst_pulse_sample", int'(SAMPLE), 0);
    chk("rst_pulse_adc_clk", ADC_CLK, 0);
    model_clear();
    q.delete();
    pat.delete();
    RESET = 0;
    SAMPLE_READY = 1;
    wait_valid(100, n);
    chk("post_rst_latency", n, 49);
    repeat (50) step();
    wait_valid(40, n);
    set_en(0);
    repeat (5) step();
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
